// File: rtl/gray_seq_gen.sv
// ---------------------------------------------------------------------------
// gray_seq_gen
//
// Stimulus/source stage placed directly upstream of the bin2gray converter.
// It steps a W-bit binary code through its whole range, counting up or down.
// Each code is held for a programmable number of extra cycles (dwell). The
// sequence runs either as a single sweep or wraps continuously. A registered
// Gray copy of the current code is provided as well, so the combinational
// converter downstream can be cross-checked cycle by cycle.
//
// Parameters:
//   W   code width in bits. Code vectors are [0:W-1], with index 0 the MSB.
//   DW  width of the dwell input.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle request to begin a sequence (accepted in IDLE only)
//   stop        abort request (honoured in RUN, blocks start in IDLE)
//   dir         0 = count up, 1 = count down (latched at accepted start)
//   cont        0 = single sweep, 1 = continuous wrap (latched at start)
//   dwell       extra hold cycles per code (latched at start)
//   bin_out     current binary code, feeds bin2gray
//   gray_out    registered Gray encoding of bin_out (same cycle)
//   step_valid  pulse in the first cycle each new code is presented
//   busy        high while a sequence is running
//   done        one-cycle pulse when a single sweep completes
// ---------------------------------------------------------------------------
module gray_seq_gen #(
  parameter int W  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          dir,
  input  logic          cont,
  input  logic [DW-1:0] dwell,
  output logic [0:W-1]  bin_out,
  output logic [0:W-1]  gray_out,
  output logic          step_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [0:W-1]  CODE_ZERO_C = {W{1'b0}};
  localparam logic [0:W-1]  CODE_ONES_C = {W{1'b1}};
  localparam logic [0:W-1]  CODE_ONE_C  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] CNT_ZERO_C  = {DW{1'b0}};
  localparam logic [DW-1:0] CNT_ONE_C   = {{(DW-1){1'b0}}, 1'b1};

  // Binary-reflected Gray encoding: MSB passes through, every other bit is
  // XORed with its more-significant neighbour.
  function automatic logic [0:W-1] bin_to_gray(input logic [0:W-1] b);
    return b ^ (b >> 1);
  endfunction

  // State and datapath registers
  state_t          state_r;
  state_t          state_nx_s;
  logic [0:W-1]    bin_r;
  logic [0:W-1]    bin_nx_s;
  logic [0:W-1]    gray_r;
  logic [0:W-1]    gray_nx_s;
  logic [DW-1:0]   cnt_r;
  logic [DW-1:0]   cnt_nx_s;
  logic [DW-1:0]   dwell_r;
  logic [DW-1:0]   dwell_nx_s;
  logic            dir_r;
  logic            dir_nx_s;
  logic            cont_r;
  logic            cont_nx_s;
  logic            step_valid_r;
  logic            step_valid_nx_s;
  logic            busy_r;
  logic            busy_nx_s;
  logic            done_r;
  logic            done_nx_s;

  // Decoded conditions
  logic            start_acc_s;
  logic            hold_end_s;
  logic            at_term_s;
  logic [0:W-1]    term_code_s;
  logic            step_s;

  // Condition decode: accepted start, end of hold, terminal code, step request
  always_comb begin
    term_code_s = dir_r ? CODE_ZERO_C : CODE_ONES_C;
    at_term_s   = (bin_r == term_code_s);
    hold_end_s  = (cnt_r == dwell_r);
    start_acc_s = (state_r == ST_IDLE) && start && !stop;
    // A step happens at the end of the hold unless this is the last code of
    // a single sweep; in continuous mode the terminal code wraps modulo 2^W.
    // stop wins over a simultaneous step.
    step_s      = (state_r == ST_RUN) && !stop && hold_end_s &&
                  (!at_term_s || cont_r);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nx_s = ST_IDLE;
        end else if (hold_end_s && at_term_s && !cont_r) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs and the datapath
  always_comb begin
    bin_nx_s        = bin_r;
    cnt_nx_s        = cnt_r;
    dir_nx_s        = dir_r;
    cont_nx_s       = cont_r;
    dwell_nx_s      = dwell_r;
    step_valid_nx_s = 1'b0;
    busy_nx_s       = (state_nx_s == ST_RUN);
    done_nx_s       = (state_nx_s == ST_DONE);
    if (start_acc_s) begin
      dir_nx_s        = dir;
      cont_nx_s       = cont;
      dwell_nx_s      = dwell;
      bin_nx_s        = dir ? CODE_ONES_C : CODE_ZERO_C;
      cnt_nx_s        = CNT_ZERO_C;
      step_valid_nx_s = 1'b1;
    end else if (step_s) begin
      // Width-W arithmetic gives the modulo-2^W wrap for free.
      bin_nx_s        = dir_r ? (bin_r - CODE_ONE_C) : (bin_r + CODE_ONE_C);
      cnt_nx_s        = CNT_ZERO_C;
      step_valid_nx_s = 1'b1;
    end else if ((state_r == ST_RUN) && !stop && !hold_end_s) begin
      cnt_nx_s = cnt_r + CNT_ONE_C;
    end else begin
      cnt_nx_s = cnt_r;
    end
    // Encoding the next binary value keeps gray_out aligned with bin_out.
    gray_nx_s = bin_to_gray(bin_nx_s);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r        <= CODE_ZERO_C;
      gray_r       <= CODE_ZERO_C;
      cnt_r        <= CNT_ZERO_C;
      dwell_r      <= CNT_ZERO_C;
      dir_r        <= 1'b0;
      cont_r       <= 1'b0;
      step_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      bin_r        <= bin_nx_s;
      gray_r       <= gray_nx_s;
      cnt_r        <= cnt_nx_s;
      dwell_r      <= dwell_nx_s;
      dir_r        <= dir_nx_s;
      cont_r       <= cont_nx_s;
      step_valid_r <= step_valid_nx_s;
      busy_r       <= busy_nx_s;
      done_r       <= done_nx_s;
    end
  end

  assign bin_out    = bin_r;
  assign gray_out   = gray_r;
  assign step_valid = step_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_gray_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_gray_seq_gen
//
// Self-checking bench for gray_seq_gen. A reference model tracks, for a
// running sequence, only the number of cycles since the start edge. The
// expected code, step_valid and completion are derived from that count
// arithmetically: code index = cycles / (dwell+1).
// Directed scenarios follow the test plan, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_gray_seq_gen;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int N  = 1 << W;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          dir;
  logic          cont;
  logic [DW-1:0] dwell;
  logic [0:W-1]  bin_out;
  logic [0:W-1]  gray_out;
  logic          step_valid;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_phase;
  int m_c;
  int m_dwell;
  int m_bin;
  bit m_dir;
  bit m_cont;

  // per-scenario activity counters
  int cnt_sv;
  int cnt_busy;
  int cnt_done;

  always #5 clk = ~clk;

  gray_seq_gen #(.W(W), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .cont       (cont),
    .dwell      (dwell),
    .bin_out    (bin_out),
    .gray_out   (gray_out),
    .step_valid (step_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int code_at(input int c);
    int idx;
    idx = (c / (m_dwell + 1)) % N;
    return m_dir ? (N - 1 - idx) : idx;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_c     = 0;
    m_dwell = 0;
    m_bin   = 0;
    m_dir   = 1'b0;
    m_cont  = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit p);
    case (m_phase)
      PH_IDLE: begin
        if (s && !p) begin
          m_phase = PH_RUN;
          m_dir   = dir;
          m_cont  = cont;
          m_dwell = int'(dwell);
          m_c     = 0;
        end
      end
      PH_RUN: begin
        if (p) begin
          m_phase = PH_IDLE;
        end else begin
          m_c++;
          if (!m_cont && m_c == N * (m_dwell + 1)) m_phase = PH_DONE;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
    if (m_phase == PH_RUN) m_bin = code_at(m_c);
  endtask

  task automatic check_outputs();
    check_eq("bin_out", bin_out, m_bin);
    check_eq("gray_out", gray_out, gray_of(m_bin));
    check_eq("step_valid", step_valid, (m_phase == PH_RUN) && (m_c % (m_dwell + 1) == 0));
    check_eq("busy", busy, m_phase == PH_RUN);
    check_eq("done", done, m_phase == PH_DONE);
  endtask

  task automatic clr_counts();
    cnt_sv   = 0;
    cnt_busy = 0;
    cnt_done = 0;
  endtask

  // one clock: drive start/stop, advance model at the edge, check 1 time unit later
  task automatic tick(input bit s, input bit p);
    start = s;
    stop  = p;
    @(posedge clk);
    model_edge(s, p);
    #1;
    check_outputs();
    cnt_sv   += int'(step_valid);
    cnt_busy += int'(busy);
    cnt_done += int'(done);
  endtask

  initial begin
    int done_at;
    int wraps;
    int i;
    bit s;
    bit p;
    logic [0:W-1] prev_gray;

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    dir   = 1'b0;
    cont  = 1'b0;
    dwell = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // A: single sweep up, dwell 0
    dir = 1'b0; cont = 1'b0; dwell = 8'd0;
    clr_counts();
    tick(1'b1, 1'b0);
    for (int k = 0; k < 20; k++) tick(1'b0, 1'b0);
    check_eq("a_step_cnt", cnt_sv, 16);
    check_eq("a_busy_cnt", cnt_busy, 16);
    check_eq("a_done_cnt", cnt_done, 1);
    check_eq("a_final_bin", bin_out, 15);
    check_eq("a_final_gray", gray_out, 8);

    // B: single sweep down, dwell 2; start/setting changes in RUN and start in DONE ignored
    dir = 1'b1; cont = 1'b0; dwell = 8'd2;
    clr_counts();
    done_at = -1;
    tick(1'b1, 1'b0);
    for (int k = 1; k <= 55; k++) begin
      s = 1'b0;
      if (k == 10) begin
        dir = 1'b0; cont = 1'b1; dwell = 8'd7; s = 1'b1;
      end
      if (m_phase == PH_DONE) s = 1'b1;
      tick(s, 1'b0);
      if (done && done_at < 0) done_at = k;
    end
    check_eq("b_done_edge", done_at, 16 * 3);
    check_eq("b_busy_cnt", cnt_busy, 48);
    check_eq("b_step_cnt", cnt_sv, 16);
    check_eq("b_done_cnt", cnt_done, 1);
    check_eq("b_final_gray", gray_out, 0);

    // C: continuous up, dwell 0, 40 cycles
    dir = 1'b0; cont = 1'b1; dwell = 8'd0;
    clr_counts();
    tick(1'b1, 1'b0);
    prev_gray = gray_out;
    wraps = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 1'b0);
      if (step_valid) begin
        check_eq("c_gray_one_bit", $countones(prev_gray ^ gray_out), 1);
        if (bin_out == 0) wraps++;
      end
      prev_gray = gray_out;
    end
    check_eq("c_wraps", wraps, 2);
    check_eq("c_busy_cnt", cnt_busy, 41);
    check_eq("c_done_cnt", cnt_done, 0);
    tick(1'b0, 1'b1);

    // D: stop in second hold cycle of code 6, dwell 3
    dir = 1'b0; cont = 1'b0; dwell = 8'd3;
    tick(1'b1, 1'b0);
    i = 0;
    while (i < 100 && !(bin_out == 6 && !step_valid)) begin
      tick(1'b0, 1'b0);
      i++;
    end
    check_eq("d_reach_bin6", bin_out, 6);
    clr_counts();
    tick(1'b0, 1'b1);
    check_eq("d_stop_busy", busy, 0);
    check_eq("d_stop_bin", bin_out, 6);
    check_eq("d_stop_gray", gray_out, 5);
    tick(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
    check_eq("d_idle_bin", bin_out, 6);
    check_eq("d_no_done", cnt_done, 0);
    check_eq("d_no_busy", cnt_busy, 0);

    // E: asynchronous reset mid-cycle at bin 9
    dir = 1'b0; cont = 1'b1; dwell = 8'd1;
    tick(1'b1, 1'b0);
    i = 0;
    while (i < 100 && bin_out != 9) begin
      tick(1'b0, 1'b0);
      i++;
    end
    check_eq("e_reach_bin9", bin_out, 9);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #3;
    rst_n = 1'b1;
    clr_counts();
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0);
    check_eq("e_idle_steps", cnt_sv, 0);
    check_eq("e_idle_busy", cnt_busy, 0);

    // R: randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      dir   = 1'($urandom % 2);
      cont  = ($urandom % 4) == 0;
      dwell = 8'($urandom % 3);
      s     = ($urandom % 6) == 0;
      p     = ($urandom % 20) == 0;
      tick(s, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
